// File: rtl/lock_ctrl_pkg.sv
// lock_ctrl_pkg: state encoding, group indices and BCD helpers shared by the
// lock session sequencer.
package lock_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_COMPARE  = 3'd2,
        S_UNLOCKED = 3'd3,
        S_LOCKOUT  = 3'd4
    } state_t;

    // First and last register-bank group of a six-digit code (three pairs)
    localparam logic [1:0] GRP_FIRST = 2'd0;
    localparam logic [1:0] GRP_LAST  = 2'd2;

    // Largest legal BCD digit
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bcd(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

    function automatic logic [2:0] grp_strobe(input logic [1:0] g);
        return 3'b001 << g;
    endfunction

endpackage

// File: rtl/led_flash_gen.sv
// led_flash_gen: alarm LED flasher. While enabled the output starts high and
// toggles every FLASH_HALF cycles; while disabled it is held low and re-armed.
module led_flash_gen #(
    parameter int unsigned FLASH_HALF = 25_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic led
);

    localparam int CNT_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLASH_HALF - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase;

    // Half-period down-counter; phase flips each time it runs out
    always_ff @(posedge clk) begin
        if (clr || !en) begin
            cnt   <= CNT_LOAD;
            phase <= 1'b0;
        end else if (cnt == '0) begin
            cnt   <= CNT_LOAD;
            phase <= ~phase;
        end else begin
            cnt   <= cnt - 1'b1;
        end
    end

    assign led = en & ~phase;

endmodule

// File: rtl/lock_session_sequencer.sv
// lock_session_sequencer: sequences keypad digit pairs into the set/entered
// password register banks, triggers the comparator, counts failures and
// enforces a timed lockout with a flashing alarm LED.
// Optional feature: define AUTO_RELOCK_EN to relock automatically after
// RELOCK_CYCLES cycles in the unlocked state without a keypad pair.
module lock_session_sequencer
    import lock_ctrl_pkg::*;
#(
    parameter int unsigned ERR_LIMIT      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 100_000_000,
    parameter int unsigned FLASH_HALF     = 25_000_000,
    parameter int unsigned RELOCK_CYCLES  = 200_000_000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       m,
    input  logic       pair_vld,
    input  logic [3:0] inA,
    input  logic [3:0] inB,
    output logic [3:0] dig_a,
    output logic [3:0] dig_b,
    output logic [2:0] ld_set,
    output logic [2:0] ld_cin,
    output logic       cmp_en,
    input  logic       match,
    output logic       unlocked,
    output logic       locked_out,
    output logic [1:0] err_cnt,
    output logic       bad_digit,
    output logic       led
);

    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0] ERR_MAX = 2'(ERR_LIMIT);

    state_t            state, state_nxt, home;
    logic [1:0]        ptr, ptr_nxt;
    logic              pw_valid, pw_valid_nxt;
    logic              sess_mode, sess_mode_nxt;
    logic [3:0]        dig_a_nxt, dig_b_nxt;
    logic [2:0]        ld_set_nxt, ld_cin_nxt;
    logic              cmp_en_nxt, unlocked_nxt, bad_digit_nxt, pair_ok;
    logic [1:0]        err_cnt_nxt, err_inc;
    logic [LOCK_W-1:0] lock_cnt, lock_cnt_nxt;
`ifdef AUTO_RELOCK_EN
    localparam int RELOCK_W = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
    localparam logic [RELOCK_W-1:0] RELOCK_LOAD = RELOCK_W'(RELOCK_CYCLES - 1);
    logic [RELOCK_W-1:0] relock_cnt, relock_cnt_nxt;
`endif

    // State and registered outputs; clr overrides every event
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= S_IDLE;
            ptr        <= GRP_FIRST;
            pw_valid   <= 1'b0;
            sess_mode  <= 1'b0;
            dig_a      <= '0;
            dig_b      <= '0;
            ld_set     <= '0;
            ld_cin     <= '0;
            cmp_en     <= 1'b0;
            unlocked   <= 1'b0;
            err_cnt    <= '0;
            bad_digit  <= 1'b0;
            lock_cnt   <= '0;
`ifdef AUTO_RELOCK_EN
            relock_cnt <= RELOCK_LOAD;
`endif
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            pw_valid   <= pw_valid_nxt;
            sess_mode  <= sess_mode_nxt;
            dig_a      <= dig_a_nxt;
            dig_b      <= dig_b_nxt;
            ld_set     <= ld_set_nxt;
            ld_cin     <= ld_cin_nxt;
            cmp_en     <= cmp_en_nxt;
            unlocked   <= unlocked_nxt;
            err_cnt    <= err_cnt_nxt;
            bad_digit  <= bad_digit_nxt;
            lock_cnt   <= lock_cnt_nxt;
`ifdef AUTO_RELOCK_EN
            relock_cnt <= relock_cnt_nxt;
`endif
        end
    end

    // Next-state and next-output decode for the entry session
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        pw_valid_nxt  = pw_valid;
        sess_mode_nxt = sess_mode;
        dig_a_nxt     = dig_a;
        dig_b_nxt     = dig_b;
        ld_set_nxt    = '0;
        ld_cin_nxt    = '0;
        cmp_en_nxt    = 1'b0;
        unlocked_nxt  = unlocked;
        err_cnt_nxt   = err_cnt;
        bad_digit_nxt = 1'b0;
        lock_cnt_nxt  = lock_cnt;
        err_inc       = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + 2'd1;
        // Setting a new code needs an empty bank or an open lock
        pair_ok       = is_bcd(inA) && is_bcd(inB) &&
                        (m || !pw_valid || state == S_UNLOCKED);
        // Rejected or aborted sessions fall back here; an open lock stays open
        home          = (state == S_UNLOCKED) ? S_UNLOCKED : S_IDLE;
`ifdef AUTO_RELOCK_EN
        relock_cnt_nxt = RELOCK_LOAD;
`endif

        case (state)
            S_IDLE, S_ENTRY, S_UNLOCKED: begin
                if (ptr != GRP_FIRST && m != sess_mode) begin
                    // Mode flipped mid-session: drop the partial entry
                    ptr_nxt   = GRP_FIRST;
                    state_nxt = home;
                end else if (pair_vld) begin
                    if (!pair_ok) begin
                        bad_digit_nxt = 1'b1;
                        ptr_nxt       = GRP_FIRST;
                        state_nxt     = home;
                    end else begin
                        dig_a_nxt = inA;
                        dig_b_nxt = inB;
                        if (ptr == GRP_FIRST) sess_mode_nxt = m;
                        if (m) begin
                            ld_cin_nxt   = grp_strobe(ptr);
                            unlocked_nxt = 1'b0;
                        end else begin
                            ld_set_nxt   = grp_strobe(ptr);
                        end
                        if (ptr == GRP_LAST) begin
                            ptr_nxt = GRP_FIRST;
                            if (m) begin
                                state_nxt = S_COMPARE;
                            end else begin
                                pw_valid_nxt = 1'b1;
                                state_nxt    = home;
                            end
                        end else begin
                            ptr_nxt   = ptr + 2'd1;
                            state_nxt = (!m && state == S_UNLOCKED) ? S_UNLOCKED : S_ENTRY;
                        end
                    end
                end
            end
            S_COMPARE: begin
                // First cycle raises cmp_en, second cycle samples match
                if (!cmp_en) begin
                    cmp_en_nxt = 1'b1;
                end else if (match) begin
                    state_nxt    = S_UNLOCKED;
                    unlocked_nxt = 1'b1;
                    err_cnt_nxt  = '0;
                end else begin
                    err_cnt_nxt = err_inc;
                    if (err_inc == ERR_MAX) begin
                        state_nxt    = S_LOCKOUT;
                        lock_cnt_nxt = LOCK_LOAD;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_LOCKOUT: begin
                if (lock_cnt == '0) begin
                    state_nxt   = S_IDLE;
                    err_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

`ifdef AUTO_RELOCK_EN
        // Idle time in the open state counts down; any pair restarts it
        if (state == S_UNLOCKED && state_nxt == S_UNLOCKED && !pair_vld) begin
            if (relock_cnt == '0) begin
                unlocked_nxt = 1'b0;
                ptr_nxt      = GRP_FIRST;
                state_nxt    = S_IDLE;
            end else begin
                relock_cnt_nxt = relock_cnt - 1'b1;
            end
        end
`endif
    end

    assign locked_out = (state == S_LOCKOUT);

    led_flash_gen #(
        .FLASH_HALF (FLASH_HALF)
    ) u_led_flash (
        .clk (clk),
        .clr (clr),
        .en  (locked_out),
        .led (led)
    );

endmodule

// File: tb/tb_lock_session_sequencer.sv
// tb_lock_session_sequencer: directed and randomized keypad sessions for the
// lock session sequencer, checked against a session-level reference.
`timescale 1ns/1ps
module tb_lock_session_sequencer;

    localparam int ERR_LIMIT      = 3;
    localparam int LOCKOUT_CYCLES = 20;
    localparam int FLASH_HALF     = 4;
    localparam int RELOCK_CYCLES  = 10;

    logic       clk = 1'b0;
    logic       clr, m, pair_vld, match;
    logic [3:0] inA, inB;
    logic [3:0] dig_a, dig_b;
    logic [2:0] ld_set, ld_cin;
    logic       cmp_en, unlocked, locked_out, bad_digit, led;
    logic [1:0] err_cnt;

    always #5 clk = ~clk;

    lock_session_sequencer #(
        .ERR_LIMIT      (ERR_LIMIT),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .FLASH_HALF     (FLASH_HALF),
        .RELOCK_CYCLES  (RELOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .m          (m),
        .pair_vld   (pair_vld),
        .inA        (inA),
        .inB        (inB),
        .dig_a      (dig_a),
        .dig_b      (dig_b),
        .ld_set     (ld_set),
        .ld_cin     (ld_cin),
        .cmp_en     (cmp_en),
        .match      (match),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .err_cnt    (err_cnt),
        .bad_digit  (bad_digit),
        .led        (led)
    );

    int tests = 0;
    int fails = 0;

    // Register-bank contents as loaded by the strobes, and session-level state
    logic [7:0] bank_set [3];
    logic [7:0] bank_cin [3];
    bit pw_valid_m, unlocked_m;
    int err_m, ptr_m;
    int clr_in_lockout = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [3:0] rnd_digit(input bit allow_bad);
        if (allow_bad && ($urandom_range(0, 7) == 0)) return 4'(10 + $urandom_range(0, 5));
        return 4'($urandom_range(0, 9));
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dig"}, {dig_a, dig_b}, 0);
        chk({tag, "_ld"}, {ld_set, ld_cin}, 0);
        chk({tag, "_flags"}, {cmp_en, unlocked, locked_out, bad_digit, led}, 0);
        chk({tag, "_err"}, err_cnt, 0);
    endtask

    task automatic do_lockout();
        for (int i = 0; i < LOCKOUT_CYCLES; i++) begin
            if (i == clr_in_lockout) begin
                clr = 1'b1; pair_vld = 1'b0;
                tick();
                clr = 1'b0;
                chk_all_zero("clr_lockout");
                pw_valid_m = 0; unlocked_m = 0; err_m = 0; ptr_m = 0;
                clr_in_lockout = -1;
                return;
            end
            chk("lock_active", locked_out, 1);
            chk("lock_led", led, ((i / FLASH_HALF) % 2) == 0);
            chk("lock_err", err_cnt, ERR_LIMIT);
            if (i > 0) chk("lock_no_strobe", {ld_set, ld_cin}, 0);
            m = 1'($urandom_range(0, 1));
            inA = rnd_digit(1); inB = rnd_digit(1);
            pair_vld = 1'($urandom_range(0, 1));
            tick();
            pair_vld = 1'b0;
        end
        chk("lock_end", locked_out, 0);
        chk("lock_end_led", led, 0);
        chk("lock_end_err", err_cnt, 0);
        chk("lock_end_strobe", {ld_set, ld_cin}, 0);
        err_m = 0;
    endtask

    task automatic do_compare();
        match = (bank_cin[0] == bank_set[0]) && (bank_cin[1] == bank_set[1]) &&
                (bank_cin[2] == bank_set[2]);
        tick();
        chk("cmp_en_high", cmp_en, 1);
        chk("cmp_no_strobe", {ld_set, ld_cin}, 0);
        tick();
        chk("cmp_en_low", cmp_en, 0);
        if (match) begin
            unlocked_m = 1; err_m = 0;
        end else begin
            err_m++;
        end
        chk("cmp_unlocked", unlocked, unlocked_m);
        chk("cmp_err", err_cnt, err_m);
        if (err_m == ERR_LIMIT) do_lockout();
        else chk("cmp_not_locked", locked_out, 0);
    endtask

    task automatic do_toggle(input bit mm);
        m = mm; pair_vld = 1'b0;
        tick();
        chk("abort_no_strobe", {ld_set, ld_cin}, 0);
        chk("abort_unlocked", unlocked, unlocked_m);
        ptr_m = 0;
    endtask

    task automatic do_pair(input bit mm, input logic [3:0] a, input logic [3:0] b);
        bit bad;
        logic [2:0] oh;
        if (ptr_m != 0 && mm != m) do_toggle(mm);
        m = mm; inA = a; inB = b; pair_vld = 1'b1;
        bad = (a > 9) || (b > 9) || (!mm && pw_valid_m && !unlocked_m);
        tick();
        pair_vld = 1'b0;
        chk("bad_digit", bad_digit, bad);
        chk("pair_not_locked", locked_out, 0);
        chk("pair_err", err_cnt, err_m);
        if (bad) begin
            chk("bad_no_strobe", {ld_set, ld_cin}, 0);
            chk("bad_unlocked", unlocked, unlocked_m);
            ptr_m = 0;
        end else begin
            oh = 3'b001 << ptr_m;
            chk("ld_set", ld_set, mm ? 3'b000 : oh);
            chk("ld_cin", ld_cin, mm ? oh : 3'b000);
            chk("dig", {dig_a, dig_b}, {a, b});
            if (mm) begin
                bank_cin[ptr_m] = {a, b};
                unlocked_m = 0;
            end else begin
                bank_set[ptr_m] = {a, b};
            end
            chk("pair_unlocked", unlocked, unlocked_m);
            ptr_m++;
            if (ptr_m == 3) begin
                ptr_m = 0;
                if (mm) do_compare();
                else pw_valid_m = 1;
            end
        end
    endtask

    task automatic enter_pw(input bit correct);
        logic [7:0] v;
        for (int g = 0; g < 3; g++) begin
            if (correct) begin
                v = bank_set[g];
            end else begin
                v = {rnd_digit(0), rnd_digit(0)};
                if (g == 0) v[7:4] = 4'((bank_set[0][7:4] + 1) % 10);
            end
            do_pair(1'b1, v[7:4], v[3:0]);
        end
    endtask

    task automatic set_pw_random();
        for (int g = 0; g < 3; g++) do_pair(1'b0, rnd_digit(1), rnd_digit(1));
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin bank_set[g] = '0; bank_cin[g] = '0; end
        pw_valid_m = 0; unlocked_m = 0; err_m = 0; ptr_m = 0;
        clr = 1'b1; m = 1'b0; pair_vld = 1'b0; match = 1'b0; inA = '0; inB = '0;
        tick();
        tick();
        chk_all_zero("reset");
        clr = 1'b0;

        // Set 12/34/56, then a further set without unlock is refused
        do_pair(1'b0, 4'd1, 4'd2);
        do_pair(1'b0, 4'd3, 4'd4);
        do_pair(1'b0, 4'd5, 4'd6);
        do_pair(1'b0, 4'd7, 4'd8);

        // Correct entry opens the lock
        enter_pw(1'b1);

        // Open lock with no keypad activity
        for (int i = 0; i < 15; i++) begin
`ifdef AUTO_RELOCK_EN
            chk("relock", unlocked, i < RELOCK_CYCLES);
`else
            chk("stay_unlocked", unlocked, 1);
`endif
            tick();
        end
`ifdef AUTO_RELOCK_EN
        unlocked_m = 0;
`endif

        // New password while open (refused if relocked), then three wrong tries
        set_pw_random();
        enter_pw(1'b0);
        enter_pw(1'b0);
        enter_pw(1'b0);

        // Digit 10 mid-entry, then a fresh session from group 0
        do_pair(1'b1, bank_set[0][7:4], bank_set[0][3:0]);
        do_pair(1'b1, 4'hA, 4'd3);
        enter_pw(1'b1);

        // Mode flip after the first entry pair aborts the session
        do_pair(1'b1, 4'd9, 4'd9);
        do_toggle(1'b0);
        enter_pw(1'b1);

        // Randomized sessions
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: enter_pw(1'b1);
                1: enter_pw(1'b0);
                2: set_pw_random();
                default: do_pair(1'($urandom_range(0, 1)), rnd_digit(1), rnd_digit(1));
            endcase
        end

        // clr in the middle of a lockout
        if (ptr_m != 0) do_toggle(~m);
        clr_in_lockout = 5;
        for (int k = 0; k < ERR_LIMIT && clr_in_lockout != -1; k++) enter_pw(1'b0);
        chk("clr_lockout_reached", clr_in_lockout, -1);

        // After clr a new password may be set and used
        do_pair(1'b0, 4'd2, 4'd4);
        do_pair(1'b0, 4'd6, 4'd8);
        do_pair(1'b0, 4'd0, 4'd1);
        enter_pw(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
